uart_tx_frm: RTL
================

Name: uart_tx_frm

Overview:
UART transmit framer. It serialises parallel bytes into start/data/parity/stop frames on the `tx` line. Bit timing is paced entirely by the `baud_trig_tx` strobe from the shared baud generator: one strobe marks one bit period. It sits between the host-side byte source (valid/ready) and the serial pin, and mirrors the receive path that consumes `baud_trig_rx`.

Parameters:
- DBIT, 8, data bits per frame (5..9), sent LSB first.
- PARITY_EN, 0, 1 = append one parity bit after the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous active-high reset.
- baud_trig_tx  input  1  one-clk bit-period strobe from baud generator.
- tx_data  input  DBIT  byte to send; sampled on acceptance.
- tx_valid  input  1  host has a byte.
- tx_ready  output  1  holding register empty; byte accepted when tx_valid & tx_ready at posedge.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  frame in progress (state != IDLE).
- tx_done_tick  output  1  one-clk pulse at end of final stop bit.

Behaviour:
- Reset (async, immediate):
  - tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0.
  - Holding register empty; state IDLE; bit counter 0.
  - Reset mid-frame abandons the frame; the line returns high at once.
- Holding register:
  - One-entry buffer. Loads tx_data on the accepting edge; tx_ready deasserts the next cycle.
  - Freed on the tick that moves its contents into the shift register; tx_ready reasserts the cycle after that tick.
  - Accepts the next byte while a frame is shifting.
- All state transitions occur only on posedge clk with baud_trig_tx=1. Between ticks everything holds.
- FSM (one transition per tick):
  - IDLE: if holding valid, load shifter, clear holding, go START, tx<=0. Else tx stays 1.
  - START: go DATA, tx<=shift[0], cnt<=0.
  - DATA:
    - If cnt<DBIT-1: shift right, cnt++, tx<=next bit.
    - Else if PARITY_EN: go PARITY, tx<=parity.
    - Else go STOP, tx<=1.
  - PARITY: go STOP, tx<=1, cnt<=0.
  - STOP:
    - If cnt<STOP_BITS-1: cnt++, tx stays 1.
    - Else the frame ends: assert tx_done_tick the next cycle.
      - If holding valid: go START directly (load shifter, tx<=0); no idle gap.
      - Else go IDLE.
- Parity is computed over the DBIT data bits of the frame being sent, latched at shifter load:
  - Even: XOR of the data bits.
  - Odd: inverted XOR.
- Each bit is held for exactly one tick period. Frame length = 1+DBIT+PARITY_EN+STOP_BITS tick periods.
- Latency: a byte accepted into an empty block while IDLE starts on the first tick strictly after the accept edge. A tick coincident with the accept edge does not start the frame.
- The host holds tx_data stable only for the accept edge.
- tx_valid with tx_ready=0 is ignored; the host must hold the byte.
- Missing ticks (dvsr unchanged): the block waits indefinitely. No timeout.
- Illegal parameter values (STOP_BITS not 1/2, DBIT outside 5..9) are flagged by an elaboration-time check.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Constants LINE_IDLE=1'b1, START_BIT=1'b0.
  - Parity function par_calc(data, odd).
- One sub-module is natural: uart_tx_hold, the one-entry valid/ready holding register. The FSM and shifter stay in uart_tx_frm.
- The baud generator is instanced outside, alongside the receiver.

Test Plan:
- Bench tick every 4 clks. Send 8'hA5, defaults:
  - tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clks.
  - tx_done_tick pulses once; tx_busy high for 40 clks.
- PARITY_EN=1, PARITY_ODD=0. Send 8'h07 → parity bit=1. With PARITY_ODD=1 → parity bit=0. Frame is 11 bit periods.
- STOP_BITS=2. Send 8'h00 then 8'hFF back-to-back:
  - Two stop periods, then the start bit of 8'hFF on the very next tick.
  - No idle gap; exactly two tx_done_tick pulses.
- Hold tx_valid high with 3 bytes:
  - tx_ready drops after the first accept, rises after that byte is loaded into the shifter, and drops again after the next accept.
  - All 3 bytes are serialised in order with no loss.
- Assert rst mid-DATA of 8'h3C:
  - tx=1, tx_ready=1, tx_busy=0 immediately (async).
  - After release, a new byte 8'h81 is transmitted correctly.
- Assert tx_valid on the same edge as a tick while IDLE:
  - The frame does not start on that tick.
  - The start bit begins on the following tick.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-level constants and the
// parity helper used by the transmit framer.
package uart_pkg;

  // State encoding stays a plain logic vector so legacy code and waveform
  // tooling can keep treating it as a 3-bit field.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t StIdle   = 3'd0;
  localparam uart_state_t StStart  = 3'd1;
  localparam uart_state_t StData   = 3'd2;
  localparam uart_state_t StParity = 3'd3;
  localparam uart_state_t StStop   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Parity over up to 9 data bits. Narrower words are zero-extended by the
  // caller, which leaves the XOR unchanged.
  function automatic logic par_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry valid/ready holding register between the host and the framer.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_data/in_valid   host byte and its valid
//   in_ready           register empty; a byte is taken when in_valid & in_ready
//   out_data/out_valid buffered byte for the framer
//   pop                framer moved the byte into its shifter this cycle
module uart_tx_hold #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          pop
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Accept and pop are mutually exclusive: accept needs the register empty,
  // pop is only issued while it is full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && !valid_q) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/uart_tx_frm.sv
// UART transmit framer: serialises buffered bytes into start / data (LSB
// first) / optional parity / stop frames, one bit per baud_trig_tx strobe.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   baud_trig_tx  one-clk bit-period strobe
//   tx_data       byte to send, sampled on acceptance
//   tx_valid      host has a byte
//   tx_ready      holding register empty
//   tx            registered serial line, idle high
//   tx_busy       frame in progress
//   tx_done_tick  one-clk pulse after the final stop bit ends
module uart_tx_frm
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_trig_tx,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_tx_frm: DBIT must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frm: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] DataLast = 4'(DBIT - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  logic [DBIT-1:0] hold_data;
  logic            hold_valid;
  logic            pop;

  uart_tx_hold #(
    .DW(DBIT)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (tx_data),
    .in_valid (tx_valid),
    .in_ready (tx_ready),
    .out_data (hold_data),
    .out_valid(hold_valid),
    .pop      (pop)
  );

  uart_state_t     state_q, state_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            load;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    if (baud_trig_tx) begin
      unique case (state_q)
        StIdle: begin
          if (hold_valid) load = 1'b1;
          else tx_d = LINE_IDLE;
        end
        StStart: begin
          state_d = StData;
          tx_d    = shift_q[0];
          cnt_d   = '0;
        end
        StData: begin
          if (cnt_q < DataLast) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
            tx_d    = shift_q[1];
          end else if (PARITY_EN != 0) begin
            state_d = StParity;
            tx_d    = par_q;
          end else begin
            state_d = StStop;
            tx_d    = LINE_IDLE;
            cnt_d   = '0;
          end
        end
        StParity: begin
          state_d = StStop;
          tx_d    = LINE_IDLE;
          cnt_d   = '0;
        end
        StStop: begin
          if (cnt_q < StopLast) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            done_d = 1'b1;
            // A buffered byte starts straight away so frames run back to back.
            if (hold_valid) load = 1'b1;
            else state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          tx_d    = LINE_IDLE;
        end
      endcase
    end

    if (load) begin
      shift_d = hold_data;
      par_d   = par_calc(9'(hold_data), PARITY_ODD != 0);
      pop     = 1'b1;
      state_d = StStart;
      tx_d    = START_BIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != StIdle);
  assign tx_done_tick = done_q;

endmodule
